// File: rtl/hist_accum_dump_if.sv
// Bus bundle for the histogram accumulator: sample input, dump request,
// backpressured readout and status flags.
//
// Handshake: a transfer happens on a rising clk edge where the source's
// valid and the sink's ready are both high. The source holds its payload
// stable while valid is high and ready is low. The sample port samples
// sample_bin on sample_valid && sample_ready. The readout port transfers one
// beat (out_data/out_index/out_last) on out_valid && out_ready.
interface hist_accum_dump_if #(
  parameter int IDX_W = 6,
  parameter int CNT_W = 8
);
  logic             sample_valid;
  logic             sample_ready;
  logic [IDX_W-1:0] sample_bin;
  logic             dump_req;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;
  logic             overflow_flag;
  logic             dropped;

  // Accumulator side.
  modport slave (
    input  sample_valid, sample_bin, dump_req, out_ready,
    output sample_ready, out_valid, out_data, out_index, out_last,
           overflow_flag, dropped
  );

  // Sample producer / readout consumer side.
  modport master (
    output sample_valid, sample_bin, dump_req, out_ready,
    input  sample_ready, out_valid, out_data, out_index, out_last,
           overflow_flag, dropped
  );
endinterface

// File: rtl/hist_accum_dump.sv
// Histogram accumulator: counts bin-index samples into NUM_BINS saturating
// counters, streams the whole histogram out on saturation or request, then
// clears itself. state_o exposes the FSM state for debug.
module hist_accum_dump #(
  parameter int NUM_BINS    = 64,
  parameter int IDX_W       = 6,
  parameter int CNT_W       = 8,
  parameter bit DUMP_ON_SAT = 1'b1
) (
  input  logic              clk,
  input  logic              bin_reset,
  hist_accum_dump_if.slave  bus,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DUMP  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W:0]   NUM_BINS_X = (IDX_W+1)'(NUM_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BINS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q [NUM_BINS];

  logic             accept;
  logic             in_range;
  logic [CNT_W-1:0] cur_cnt;
  logic             inc_en;
  logic             clr_all;
  logic             sat_trig;

  // Sample acceptance and the current count of the addressed bin.
  always_comb begin
    accept   = bus.sample_valid && (state_q == S_IDLE);
    in_range = ({1'b0, bus.sample_bin} < NUM_BINS_X);
    cur_cnt  = in_range ? cnt_q[bus.sample_bin] : '0;
  end

  // Next-state logic: counting in IDLE, readout pointer in DUMP, wipe in CLEAR.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    drop_d   = 1'b0;
    inc_en   = 1'b0;
    clr_all  = 1'b0;
    sat_trig = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!in_range) begin
            drop_d = 1'b1;
          end else if (cur_cnt != CNT_MAX) begin
            inc_en = 1'b1;
            // The increment that fills the bin counts, then triggers a dump.
            if (DUMP_ON_SAT && (cur_cnt == (CNT_MAX - CNT_ONE))) begin
              ovf_d    = 1'b1;
              sat_trig = 1'b1;
            end
          end else begin
            // Already full: hold at saturation and flag it.
            ovf_d = 1'b1;
          end
        end
        // Saturation and request in the same cycle collapse into one dump.
        if (sat_trig || bus.dump_req) begin
          state_d = S_DUMP;
          ptr_d   = '0;
        end
      end
      S_DUMP: begin
        if (bus.out_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = S_CLEAR;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + IDX_ONE;
          end
        end
      end
      S_CLEAR: begin
        clr_all = 1'b1;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Bin counters: single increment port, bulk clear after a dump.
  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= '0;
    end else if (clr_all) begin
      for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= '0;
    end else if (inc_en) begin
      cnt_q[bus.sample_bin] <= cur_cnt + CNT_ONE;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  always_comb begin
    bus.sample_ready  = (state_q == S_IDLE);
    bus.out_valid     = (state_q == S_DUMP);
    bus.out_index     = ptr_q;
    bus.out_data      = (state_q == S_DUMP) ? cnt_q[ptr_q] : '0;
    bus.out_last      = (state_q == S_DUMP) && (ptr_q == LAST_IDX);
    bus.overflow_flag = ovf_q;
    bus.dropped       = drop_q;
    state_o           = state_q;
  end

endmodule

// File: tb/tb_hist_accum_dump.sv
// Bench for hist_accum_dump: a saturating-dump instance under random traffic
// with a histogram model and beat scoreboard, plus a silent-saturation
// instance exercised with a directed sequence.
module tb_hist_accum_dump;

  localparam int NB1  = 40;
  localparam int IW1  = 6;
  localparam int CW1  = 4;
  localparam int MAX1 = 15;
  localparam int W1   = 1 + IW1 + CW1;
  localparam int NB2  = 8;
  localparam int IW2  = 3;
  localparam int CW2  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic bin_reset;
  always #5 clk = ~clk;

  hist_accum_dump_if #(.IDX_W(IW1), .CNT_W(CW1)) if1 ();
  hist_accum_dump_if #(.IDX_W(IW2), .CNT_W(CW2)) if2 ();
  logic [1:0] st1, st2;

  hist_accum_dump #(.NUM_BINS(NB1), .IDX_W(IW1), .CNT_W(CW1), .DUMP_ON_SAT(1'b1)) dut1 (
    .clk(clk), .bin_reset(bin_reset), .bus(if1), .state_o(st1)
  );
  hist_accum_dump #(.NUM_BINS(NB2), .IDX_W(IW2), .CNT_W(CW2), .DUMP_ON_SAT(1'b0)) dut2 (
    .clk(clk), .bin_reset(bin_reset), .bus(if2), .state_o(st2)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (dut1) ----------------
  // Histogram as an int array; phase 0 = accepting, 1 = streaming, 2 = wiping.
  logic [W1-1:0] exp_q[$];
  int mcnt [NB1];
  int phase;
  int beats_left;
  bit movf;
  bit exp_drop;

  task automatic model_reset();
    for (int i = 0; i < NB1; i++) mcnt[i] = 0;
    phase      = 0;
    beats_left = 0;
    movf       = 1'b0;
    exp_drop   = 1'b0;
  endtask

  function automatic logic [W1-1:0] beat1(input int last, input int idx, input int data);
    logic [IW1-1:0] i_v;
    logic [CW1-1:0] d_v;
    i_v = IW1'(idx);
    d_v = CW1'(data);
    return {last[0], i_v, d_v};
  endfunction

  always @(negedge clk) begin
    if (!bin_reset) begin
      check("sample_ready", int'(if1.sample_ready), (phase == 0) ? 1 : 0);
      check("out_valid",    int'(if1.out_valid),    (phase == 1) ? 1 : 0);
      check("overflow",     int'(if1.overflow_flag), int'(movf));
      check("dropped",      int'(if1.dropped),       int'(exp_drop));
      exp_drop = 1'b0;
      case (phase)
        0: begin
          bit trig;
          trig = 1'b0;
          if (if1.sample_valid) begin
            int b;
            b = int'(if1.sample_bin);
            if (b >= NB1) exp_drop = 1'b1;
            else if (mcnt[b] < MAX1) begin
              mcnt[b]++;
              if (mcnt[b] == MAX1) begin
                movf = 1'b1;
                trig = 1'b1;
              end
            end else movf = 1'b1;
          end
          if (trig || if1.dump_req) begin
            for (int i = 0; i < NB1; i++) begin
              exp_q.push_back(beat1((i == NB1 - 1) ? 1 : 0, i, mcnt[i]));
              mcnt[i] = 0;
            end
            phase      = 1;
            beats_left = NB1;
          end
        end
        1: begin
          if (if1.out_ready) begin
            beats_left--;
            if (beats_left == 0) phase = 2;
          end
        end
        default: begin
          phase = 0;
          movf  = 1'b0;
        end
      endcase
    end
  end

  // ---------------- scoreboard monitor (dut1 readout) ----------------
  logic [W1-1:0] held_w;
  bit            was_stalled = 1'b0;

  always @(negedge clk) begin
    logic [W1-1:0] w;
    w = {if1.out_last, if1.out_index, if1.out_data};
    if (bin_reset) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled && if1.out_valid) check("stall_stable", int'(w), int'(held_w));
      if (if1.out_valid && if1.out_ready) begin
        if (exp_q.size() == 0) check("beat_unexpected", int'(w), -1);
        else check("beat", int'(w), int'(exp_q.pop_front()));
      end
      was_stalled = if1.out_valid && !if1.out_ready;
      held_w      = w;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive1(input bit v, input int bin, input bit dr, input bit rdy);
    @(posedge clk);
    #1;
    if1.sample_valid = v;
    if1.sample_bin   = IW1'(bin);
    if1.dump_req     = dr;
    if1.out_ready    = rdy;
  endtask

  task automatic idle1(input int n);
    for (int i = 0; i < n; i++) drive1(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic drive2(input bit v, input int bin, input bit dr, input bit rdy);
    @(posedge clk);
    #1;
    if2.sample_valid = v;
    if2.sample_bin   = IW2'(bin);
    if2.dump_req     = dr;
    if2.out_ready    = rdy;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit found;
    bin_reset = 1'b1;
    if1.sample_valid = 1'b0; if1.sample_bin = '0; if1.dump_req = 1'b0; if1.out_ready = 1'b0;
    if2.sample_valid = 1'b0; if2.sample_bin = '0; if2.dump_req = 1'b0; if2.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_ready", int'(if1.sample_ready), 1);
    check("rst_out_valid",    int'(if1.out_valid), 0);
    check("rst_out_last",     int'(if1.out_last), 0);
    check("rst_overflow",     int'(if1.overflow_flag), 0);
    check("rst_dropped",      int'(if1.dropped), 0);
    check("rst_out_data",     int'(if1.out_data), 0);
    check("rst_out_index",    int'(if1.out_index), 0);
    check("rst_state",        int'(st1), 0);
    check("rst2_sample_ready", int'(if2.sample_ready), 1);
    bin_reset = 1'b0;

    // Five samples to bin 3, then a requested dump.
    for (int i = 0; i < 5; i++) drive1(1'b1, 3, 1'b0, 1'b1);
    drive1(1'b0, 0, 1'b1, 1'b1);
    idle1(NB1 + 5);

    // Out-of-range samples only, then a dump that must read all zeros.
    drive1(1'b1, 45, 1'b0, 1'b1);
    drive1(1'b1, 63, 1'b0, 1'b1);
    drive1(1'b0, 0, 1'b1, 1'b1);
    idle1(NB1 + 5);

    // Sample and request in the same cycle: the sample lands in the dump.
    drive1(1'b1, 12, 1'b1, 1'b1);
    idle1(NB1 + 5);

    // Saturate one bin: auto dump right after the filling sample.
    for (int i = 0; i < MAX1; i++) drive1(1'b1, 10, 1'b0, 1'b1);
    idle1(NB1 + 5);

    // Dump with out_ready toggling every cycle.
    for (int i = 0; i < 4; i++) drive1(1'b1, $urandom_range(0, NB1 - 1), 1'b0, 1'b1);
    drive1(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 2 * NB1 + 4; i++) drive1(1'b0, 0, 1'b0, (i % 2) == 0);
    idle1(NB1 + 5);

    // Random traffic with random backpressure and occasional requests.
    for (int i = 0; i < 3000; i++)
      drive1(($urandom_range(0, 3) != 0), $urandom_range(0, 47),
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1));
    idle1(2 * NB1 + 10);

    // Reset while beat 20 of a dump is presented.
    for (int i = 0; i < 3; i++) drive1(1'b1, 7, 1'b0, 1'b1);
    drive1(1'b0, 0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive1(1'b0, 0, 1'b0, 1'b1);
      if (phase == 1 && beats_left == NB1 - 20) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_beat20", int'(found), 1);
    check("abort_index_pre", int'(if1.out_index), 20);
    #1;
    bin_reset = 1'b1;
    #1;
    check("abort_out_valid", int'(if1.out_valid), 0);
    check("abort_sample_ready", int'(if1.sample_ready), 1);
    check("abort_state", int'(st1), 0);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    bin_reset = 1'b0;
    drive1(1'b0, 0, 1'b1, 1'b1);
    idle1(NB1 + 5);

    // Drain whatever is still in flight.
    idle1(2 * NB1 + 10);
    check("queue_drained", exp_q.size(), 0);
    check("model_idle", phase, 0);

    // Silent saturation instance: 20 samples to bin 0.
    for (int i = 0; i < 20; i++) begin
      drive2(1'b1, 0, 1'b0, 1'b1);
      check("sat0_sample_ready", int'(if2.sample_ready), 1);
    end
    drive2(1'b0, 0, 1'b0, 1'b1);
    check("sat0_overflow", int'(if2.overflow_flag), 1);
    check("sat0_no_autodump", int'(if2.out_valid), 0);
    check("sat0_state", int'(st2), 0);
    drive2(1'b0, 0, 1'b1, 1'b1);
    drive2(1'b0, 0, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (if2.out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("sat0_dump_start", int'(found), 1);
    for (int i = 0; i < NB2; i++) begin
      check("sat0_index", int'(if2.out_index), i);
      check("sat0_data", int'(if2.out_data), (i == 0) ? 15 : 0);
      check("sat0_last", int'(if2.out_last), (i == NB2 - 1) ? 1 : 0);
      @(negedge clk);
    end
    check("sat0_clear_valid", int'(if2.out_valid), 0);
    check("sat0_clear_ready", int'(if2.sample_ready), 0);
    @(negedge clk);
    check("sat0_after_overflow", int'(if2.overflow_flag), 0);
    check("sat0_after_ready", int'(if2.sample_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
